// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrating output multiplexer.
// No logic; arbitration mode encodings and an elaboration-time log2.
// Backpressure: n/a.
package arb_mux_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/arb_mux_if.sv
// N-channel request side plus single registered output side of arb_mux.
// Latency: n/a (wires only).
// Backpressure: valid/ready on every input channel and on the output.
interface arb_mux_if
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int IDXW  = 3
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [IDXW-1:0]    out_src;
    logic               out_valid;
    logic               out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/arb_mux_rr_pick.sv
// Rotating / fixed priority search: first set req bit starting at base (or at 0).
// Latency: combinational.
// Backpressure: none; pure function of req/base/mode.
module arb_mux_rr_pick
    import arb_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int IDXW = 3
) (
    input  logic [N-1:0]    req,
    input  logic [IDXW-1:0] base,
    input  logic            mode,
    output logic            any,
    output logic [IDXW-1:0] idx
);
    logic [IDXW-1:0] start;
    logic [2*N-1:0]  dbl;
    logic [N-1:0]    rot;
    int              off;
    int              sum;

    always_comb begin
        start = mode ? '0 : base;
        // rot[k] is req[(start + k) mod N]; lowest set bit of rot is the winner offset
        dbl   = {req, req} >> start;
        rot   = dbl[N-1:0];
        any   = |req;
        off   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = k;
        end
        sum = int'(start) + off;
        if (sum >= N) sum = sum - N;
        idx = IDXW'(sum);
    end
endmodule

// File: rtl/arb_mux.sv
// N-way arbitrating mux into a one-entry registered output stage.
// Latency: 1 cycle from input acceptance to out_valid; 1 word/cycle sustained.
// Backpressure: no grant while the held word is stalled; drain and refill in the same cycle.
module arb_mux
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int IDXW  = 3,
    parameter int MODE  = MODE_RR
) (
    input  logic     clk,
    input  logic     reset,
    arb_mux_if.slave bus
);
    if (N < 2 || N > 8 || IDXW < clog2(N) || (MODE != MODE_RR && MODE != MODE_FIXED)) begin : g_param_err
        $error("arb_mux: illegal parameter combination");
    end

    logic [IDXW-1:0]  ptr;
    logic [IDXW-1:0]  win;
    logic [IDXW-1:0]  ptr_nxt;
    logic             any;
    logic             load;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] out_data_q;
    logic [IDXW-1:0]  out_src_q;
    logic             out_valid_q;

    arb_mux_rr_pick #(.N(N), .IDXW(IDXW)) u_pick (
        .req  (bus.in_valid),
        .base (ptr),
        .mode (MODE == MODE_FIXED),
        .any  (any),
        .idx  (win)
    );

    assign load     = !out_valid_q || bus.out_ready;
    assign sel_data = WIDTH'(bus.in_data >> (int'(win) * WIDTH));
    assign ptr_nxt  = (win == IDXW'(N - 1)) ? '0 : win + 1'b1;

    // Grant is suppressed during reset so nothing is consumed on the flushing edge.
    always_comb begin
        bus.in_ready = '0;
        if (!reset && load && any) bus.in_ready = {{(N-1){1'b0}}, 1'b1} << win;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ptr         <= '0;
        end else if (load) begin
            if (any) begin
                out_data_q  <= sel_data;
                out_src_q   <= win;
                out_valid_q <= 1'b1;
                if (MODE == MODE_RR) ptr <= ptr_nxt;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: doc/arb_mux.md
Name: arb_mux

Overview:
- Parametrised N-channel arbitrating multiplexer with valid/ready handshakes on every input and on the output.
- Succeeds the fixed 2/4/8-way combinational selectors.
- Selection is made internally, by round-robin or fixed priority, instead of by an external select code.
- The result goes into a one-entry registered output stage with backpressure, for shared-resource access in the pipeline (e.g. multiple requesters to one bus/port).

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- N, 4, number of input channels; legal range 2..8.
- IDXW, 3, width of the channel index; must satisfy 2^IDXW >= N.
- MODE, 0, arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  channel i presents a request.
- in_ready  output  N  one-hot (or zero) grant/accept; a transfer on channel i occurs when in_valid[i] && in_ready[i].
- out_data  output  WIDTH  registered selected data.
- out_src  output  IDXW  index of the channel that produced out_data.
- out_valid  output  1  output stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset (clk edge with reset=1): out_valid=0, out_data=0, out_src=0, rr pointer ptr=0. in_ready=0 while reset is high, regardless of other inputs.
- load = !out_valid || out_ready. The output stage can take a new word this cycle.
- Winner search:
  - MODE 0: first i with in_valid[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - MODE 1: lowest i with in_valid[i]=1; ptr is unused and stays 0.
- in_ready[winner] = load && (|in_valid). All other in_ready bits are 0. in_ready is combinational and may depend on out_ready and in_valid in the same cycle.
- On the edge with load && (|in_valid):
  - out_data <= in_data[winner], out_src <= winner, out_valid <= 1.
  - MODE 0 only: ptr <= (winner == N-1) ? 0 : winner+1.
- On the edge with load && !(|in_valid): out_valid <= 0; out_data/out_src hold their old values; ptr holds.
- On the edge with !load (out_valid && !out_ready): out_data, out_src, out_valid and ptr all hold. Inputs are not accepted.
- Latency: 1 cycle from input acceptance to out_valid. Sustained throughput is 1 word/cycle when out_ready=1.
- Simultaneous output drain and refill in one cycle is required (no bubble).
- Fairness, MODE 0: with all channels continuously valid and out_ready=1, grants rotate 0,1,…,N-1,0. No channel waits more than N-1 grants.
- Winner selection ignores in_valid bits at index >= N (none exist); out_src never exceeds N-1.
- Reset mid-stream: a word held in the output stage is discarded; out_valid drops on that edge; no input is accepted in that cycle.
- Input channels may deassert in_valid without a grant. The block imposes no input-side stability requirement.

Decomposition:
- Shared package: MODE_RR=0 and MODE_FIXED=1 constants; a clog2 helper used to check IDXW against N.
- Sub-module rr_pick (combinational):
  - inputs: req[N], base[IDXW], mode.
  - outputs: any, idx[IDXW].
  - Implements the rotating/fixed priority search.
- arb_mux contains only the output register, the pointer and the handshake glue.

Test Plan (N=4, WIDTH=32 unless stated):
- Reset then idle: reset=1 for 2 cycles, in_valid=0 → out_valid=0, out_data=0, out_src=0, in_ready=0000 throughout.
- Single channel: in_valid=0100, in_data[2]=32'hDEAD_BEEF, out_ready=1 → in_ready=0100 that cycle; next cycle out_valid=1, out_data=DEADBEEF, out_src=2.
- Round-robin rotation, MODE 0: in_valid=1111, out_ready=1, data[i]=i+1 for 8 cycles → out_src sequence 0,1,2,3,0,1,2,3; out_data 1,2,3,4,1,…
- Fixed priority, MODE 1: in_valid=1010 held 3 cycles → out_src=1 each cycle, in_ready[3] never asserted.
- Backpressure: output holds src 0 with out_ready=0 for 3 cycles, in_valid=1111 → in_ready=0000, out_data/out_src stable. Raise out_ready → same-cycle in_ready=0010; next cycle out_src=1.
- Reset mid-operation: out_valid=1, out_ready=0, ptr=2; assert reset for 1 cycle → out_valid=0, ptr=0. With in_valid=1111 after release, the first grant is channel 0.
